can_clic_dispatch: RTL and testbench
====================================

# can_clic_dispatch

Interrupt dispatch and nesting controller sitting directly downstream of the CLIC priority arbiter. It consumes the arbiter's combinational winner (valid, index, priority), decides whether that winner may preempt the currently running level, and presents a stable request to the core through a request/acknowledge handshake. It tracks nested handler priorities on a bounded LIFO stack and emits a one-cycle clear pulse for the taken entry's pending bit upstream.

## Interface
- PRIO_BITS, 3, width of an entry priority; priority 0 never preempts
- INDEX_BITS, 2, width of an entry index
- DEPTH, 4, maximum nesting depth (stack entries); must be ≥1
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- arb_valid  in  1  arbiter has a winner
- arb_index  in  INDEX_BITS  winning entry index
- arb_prio  in  PRIO_BITS  winning entry priority
- irq_req  out  1  request to core
- irq_index  out  INDEX_BITS  requested entry index, stable while irq_req
- irq_prio  out  PRIO_BITS  requested priority, stable while irq_req
- irq_ack  in  1  core accepts request (handler entered)
- irq_ret  in  1  core returns from current handler
- clr_pend  out  1  one-cycle pulse: clear pending bit of clr_index
- clr_index  out  INDEX_BITS  entry to clear
- cur_prio  out  PRIO_BITS  priority of running level (0 = thread level)
- nest_level  out  $clog2(DEPTH+1)  number of active handlers
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, REQ.
- Preempt condition: arb_valid && arb_prio > cur_prio (strict) && nest_level < DEPTH.
- IDLE: if preempt condition, latch arb_index/arb_prio into request registers, go REQ. Otherwise stay.
- REQ: irq_req=1, irq_index/irq_prio from latches; arbiter changes are ignored (no re-arbitration while requesting). On irq_ack: push cur_prio, cur_prio←irq_prio, nest_level+1, clr_pend pulse with clr_index=irq_index, go IDLE.
- irq_ret (IDLE or REQ, without irq_ack): if nest_level>0, pop: cur_prio←top, nest_level−1; else ignore and set err.
- irq_ret and irq_ack same cycle: ack processed, ret ignored, err set.
- If a ret in REQ lowers cur_prio, request stays valid and unchanged.
- Stack full (nest_level==DEPTH): no new request issued; existing REQ still completes only if it was issued before full (cannot happen, since issue requires not full and only ack pushes).
- err cleared only by reset.

## Timing
- Reset values: state IDLE, irq_req 0, irq_index 0, irq_prio 0, clr_pend 0, clr_index 0, cur_prio 0, nest_level 0, err 0, stack contents 0.
- Arbiter input qualifying at cycle N → irq_req high at N+1.
- irq_ack at cycle M → irq_req low, clr_pend high, cur_prio/nest_level updated at M+1; clr_pend low at M+2.
- Earliest next request: preempt evaluated in IDLE at M+1 against new cur_prio → irq_req at M+2.
- irq_ret at cycle R → cur_prio/nest_level updated at R+1.
- All outputs registered; no combinational input-to-output path.
- Reset mid-REQ: request dropped immediately (async), stack emptied.

## Configuration
- CAN_CLIC_THRESHOLD_EN defined: extra input threshold (PRIO_BITS); preempt condition uses arb_prio > max(cur_prio, threshold); threshold sampled each cycle, an issued request is not withdrawn if threshold rises.
- Undefined: no threshold port; condition uses cur_prio only.

## Structure
- Package can_clic_pkg: prio_t, index_t typedefs, dispatch state enum, shared with arbiter.
- Sub-module can_clic_prio_stack: DEPTH-entry LIFO of prio_t with push, pop, top, count; full/empty flags; push when full and pop when empty are no-ops.

## Test plan
- Single interrupt: arb_valid, index 2, prio 5 → irq_req next cycle with index 2/prio 5; ack → cur_prio 5, nest_level 1, clr_pend one cycle index 2; ret → cur_prio 0, nest_level 0.
- Preemption: running prio 3; arbiter prio 3 → no request; prio 6 → request, ack → cur_prio 6, nest 2; two rets restore 3 then 0.
- Request stability: in REQ with prio 4 latched, arbiter switches to prio 7 index 1 → irq_index/irq_prio stay at latched values until ack.
- Stack full: DEPTH=4, nest to prios 1,2,3,4; arbiter prio 7 → no irq_req; one ret → request issued next-but-one cycle.
- Errors: ret at nest_level 0 → err=1, state unchanged; ack+ret same cycle → ack taken, err=1; err stays until rst_n low.
- Threshold (macro defined): threshold 5, cur_prio 0, arbiter prio 4 → no request; prio 6 → request.

Source files
------------

// File: rtl/can_clic_pkg.sv
// ----------------------------------------------------------------------------
// can_clic_pkg
// Types shared by the CLIC arbiter and the dispatch/nesting controller.
//   prio_t / index_t    : entry priority and index at the default geometry
//   dispatch_state_e    : dispatch FSM encoding
//   max_prio()          : larger of two priorities at the default geometry
// Optional feature macro used by the dispatcher: CAN_CLIC_THRESHOLD_EN.
// ----------------------------------------------------------------------------
package can_clic_pkg;

    localparam int CLIC_PRIO_BITS  = 3;
    localparam int CLIC_INDEX_BITS = 2;
    localparam int CLIC_DEPTH      = 4;

    typedef logic [CLIC_PRIO_BITS-1:0]  prio_t;
    typedef logic [CLIC_INDEX_BITS-1:0] index_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } dispatch_state_e;

    function automatic prio_t max_prio(input prio_t a, input prio_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/can_clic_prio_stack.sv
// ----------------------------------------------------------------------------
// can_clic_prio_stack
// DEPTH-entry LIFO of priorities holding the preempted levels of nested
// handlers. Implemented as a shift stack: entry 0 is always the top, so no
// pointer indexing is needed. Push when full and pop when empty are no-ops;
// if both are requested together, push wins.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_data     push a priority
//   pop                 discard the top entry
//   top                 current top entry (0 when empty)
//   count               number of valid entries
//   full, empty         occupancy flags
// ----------------------------------------------------------------------------
module can_clic_prio_stack #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;

    // NOTE: the storage is reset like any other state because a popped level
    // must read back as 0 (thread level) and entries vacated by a pop are
    // refilled with zeros; without a reset the first pops would expose X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
        end else if (do_push) begin
            mem_q[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
            count_q <= count_q + CW'(1);
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
            mem_q[DEPTH-1] <= '0;
            count_q <= count_q - CW'(1);
        end
    end

    assign top   = mem_q[0];
    assign count = count_q;

endmodule

// File: rtl/can_clic_dispatch.sv
// ----------------------------------------------------------------------------
// can_clic_dispatch
// Sits behind the CLIC priority arbiter. Decides whether the arbiter winner
// may preempt the running level, holds a stable request to the core until it
// is acknowledged, tracks nested handler priorities on a LIFO and pulses the
// pending-clear for the taken entry.
// Optional feature: define CAN_CLIC_THRESHOLD_EN to add the `threshold` input;
// a winner must then exceed both cur_prio and threshold.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   arb_valid/arb_index/arb_prio    arbiter winner (combinational upstream)
//   threshold                       level threshold (macro builds only)
//   irq_req/irq_index/irq_prio      request to core, stable while irq_req
//   irq_ack                         core entered the requested handler
//   irq_ret                         core returned from the current handler
//   clr_pend/clr_index              one-cycle pending-clear pulse
//   cur_prio                        running level priority (0 = thread)
//   nest_level                      number of active handlers
//   err                             sticky protocol error
// All outputs are registered.
// ----------------------------------------------------------------------------
module can_clic_dispatch
    import can_clic_pkg::*;
#(
    parameter int PRIO_BITS  = CLIC_PRIO_BITS,
    parameter int INDEX_BITS = CLIC_INDEX_BITS,
    parameter int DEPTH      = CLIC_DEPTH,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arb_valid,
    input  logic [INDEX_BITS-1:0] arb_index,
    input  logic [PRIO_BITS-1:0]  arb_prio,
`ifdef CAN_CLIC_THRESHOLD_EN
    input  logic [PRIO_BITS-1:0]  threshold,
`endif
    output logic                  irq_req,
    output logic [INDEX_BITS-1:0] irq_index,
    output logic [PRIO_BITS-1:0]  irq_prio,
    input  logic                  irq_ack,
    input  logic                  irq_ret,
    output logic                  clr_pend,
    output logic [INDEX_BITS-1:0] clr_index,
    output logic [PRIO_BITS-1:0]  cur_prio,
    output logic [LW-1:0]         nest_level,
    output logic                  err
);

    dispatch_state_e       state_q, state_d;
    logic [INDEX_BITS-1:0] req_index_q;
    logic [PRIO_BITS-1:0]  req_prio_q;
    logic [PRIO_BITS-1:0]  cur_prio_q;
    logic                  clr_pend_q;
    logic [INDEX_BITS-1:0] clr_index_q;
    logic                  err_q;

    logic                  stk_full;
    logic                  stk_empty;
    logic [PRIO_BITS-1:0]  stk_top;
    logic [LW-1:0]         stk_count;

    logic [PRIO_BITS-1:0]  floor_prio;
    logic                  preempt;
    logic                  load_req;
    logic                  take;
    logic                  pop;
    logic                  set_err;

    // Level a winner has to beat. Priority 0 can never beat it since the
    // comparison is strict and the floor is never below 0.
`ifdef CAN_CLIC_THRESHOLD_EN
    assign floor_prio = (threshold > cur_prio_q) ? threshold : cur_prio_q;
`else
    assign floor_prio = cur_prio_q;
`endif

    assign preempt = arb_valid && (arb_prio > floor_prio) && !stk_full;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        take     = 1'b0;
        pop      = 1'b0;
        set_err  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (preempt) begin
                    load_req = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // The latched request is held; arbiter changes are ignored.
                if (irq_ack) begin
                    take    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A return colliding with an ack is dropped as a protocol error; a
        // return with nothing nested is likewise an error.
        if (irq_ret) begin
            if (take || stk_empty) set_err = 1'b1;
            else                   pop     = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_index_q <= '0;
            req_prio_q  <= '0;
            cur_prio_q  <= '0;
            clr_pend_q  <= 1'b0;
            clr_index_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= take;
            if (set_err) err_q <= 1'b1;
            if (load_req) begin
                req_index_q <= arb_index;
                req_prio_q  <= arb_prio;
            end
            if (take) begin
                cur_prio_q  <= req_prio_q;
                clr_index_q <= req_index_q;
            end else if (pop) begin
                cur_prio_q <= stk_top;
            end
        end
    end

    // The stack holds the level that was running before each handler entry.
    can_clic_prio_stack #(
        .WIDTH (PRIO_BITS),
        .DEPTH (DEPTH)
    ) u_prio_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (take),
        .push_data (cur_prio_q),
        .pop       (pop),
        .top       (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign irq_req    = (state_q == ST_REQ);
    assign irq_index  = req_index_q;
    assign irq_prio   = req_prio_q;
    assign clr_pend   = clr_pend_q;
    assign clr_index  = clr_index_q;
    assign cur_prio   = cur_prio_q;
    assign nest_level = stk_count;
    assign err        = err_q;

endmodule

// File: tb/tb_can_clic_dispatch.sv
// ----------------------------------------------------------------------------
// tb_can_clic_dispatch
// Directed self-checking bench for can_clic_dispatch (default geometry:
// PRIO_BITS=3, INDEX_BITS=2, DEPTH=4). Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at the same point after the next edge.
// Build with CAN_CLIC_THRESHOLD_EN defined to add the threshold case.
// ----------------------------------------------------------------------------
module tb_can_clic_dispatch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arb_valid = 1'b0;
    logic [1:0] arb_index = '0;
    logic [2:0] arb_prio = '0;
`ifdef CAN_CLIC_THRESHOLD_EN
    logic [2:0] threshold = '0;
`endif
    logic       irq_req;
    logic [1:0] irq_index;
    logic [2:0] irq_prio;
    logic       irq_ack = 1'b0;
    logic       irq_ret = 1'b0;
    logic       clr_pend;
    logic [1:0] clr_index;
    logic [2:0] cur_prio;
    logic [2:0] nest_level;
    logic       err;

    int tests_run    = 0;
    int tests_failed = 0;

    can_clic_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_valid  (arb_valid),
        .arb_index  (arb_index),
        .arb_prio   (arb_prio),
`ifdef CAN_CLIC_THRESHOLD_EN
        .threshold  (threshold),
`endif
        .irq_req    (irq_req),
        .irq_index  (irq_index),
        .irq_prio   (irq_prio),
        .irq_ack    (irq_ack),
        .irq_ret    (irq_ret),
        .clr_pend   (clr_pend),
        .clr_index  (clr_index),
        .cur_prio   (cur_prio),
        .nest_level (nest_level),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied away from any clock edge.
    task automatic do_reset();
        arb_valid = 1'b0;
        irq_ack   = 1'b0;
        irq_ret   = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    // Request an entry and acknowledge it on the following cycle.
    task automatic take(input logic [1:0] idx, input logic [2:0] prio);
        arb_valid = 1'b1;
        arb_index = idx;
        arb_prio  = prio;
        tick();
        arb_valid = 1'b0;
        irq_ack   = 1'b1;
        tick();
        irq_ack   = 1'b0;
    endtask

    task automatic ret_once();
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        #3;
        check("rst_irq_req",   32'(irq_req),    0);
        check("rst_irq_index", 32'(irq_index),  0);
        check("rst_irq_prio",  32'(irq_prio),   0);
        check("rst_clr_pend",  32'(clr_pend),   0);
        check("rst_clr_index", 32'(clr_index),  0);
        check("rst_cur_prio",  32'(cur_prio),   0);
        check("rst_nest",      32'(nest_level), 0);
        check("rst_err",       32'(err),        0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- single interrupt ----------------
        arb_valid = 1'b1; arb_index = 2'd2; arb_prio = 3'd5;
        tick();
        check("single_req",   32'(irq_req),   1);
        check("single_index", 32'(irq_index), 2);
        check("single_prio",  32'(irq_prio),  5);
        arb_valid = 1'b0;
        tick();
        check("single_req_hold", 32'(irq_req), 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("single_ack_req",   32'(irq_req),    0);
        check("single_clr_pend",  32'(clr_pend),   1);
        check("single_clr_index", 32'(clr_index),  2);
        check("single_cur_prio",  32'(cur_prio),   5);
        check("single_nest",      32'(nest_level), 1);
        tick();
        check("single_clr_low",   32'(clr_pend),   0);
        ret_once();
        check("single_ret_cur",   32'(cur_prio),   0);
        check("single_ret_nest",  32'(nest_level), 0);
        check("single_err",       32'(err),        0);

        // ---------------- preemption ----------------
        take(2'd0, 3'd3);
        check("pre_cur3", 32'(cur_prio), 3);
        arb_valid = 1'b1; arb_index = 2'd1; arb_prio = 3'd3;
        tick();
        check("pre_equal_noreq", 32'(irq_req), 0);
        arb_prio = 3'd6;
        tick();
        check("pre_req6",  32'(irq_req),  1);
        check("pre_prio6", 32'(irq_prio), 6);
        arb_valid = 1'b0; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("pre_cur6",  32'(cur_prio),   6);
        check("pre_nest2", 32'(nest_level), 2);
        ret_once();
        check("pre_ret1_cur",  32'(cur_prio),   3);
        check("pre_ret1_nest", 32'(nest_level), 1);
        ret_once();
        check("pre_ret2_cur",  32'(cur_prio),   0);
        check("pre_ret2_nest", 32'(nest_level), 0);

        // ---------------- request stability ----------------
        arb_valid = 1'b1; arb_index = 2'd3; arb_prio = 3'd4;
        tick();
        check("stab_req", 32'(irq_req), 1);
        arb_index = 2'd1; arb_prio = 3'd7;
        tick();
        check("stab_index", 32'(irq_index), 3);
        check("stab_prio",  32'(irq_prio),  4);
        tick();
        check("stab_index2", 32'(irq_index), 3);
        check("stab_prio2",  32'(irq_prio),  4);
        arb_valid = 1'b0; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("stab_cur",       32'(cur_prio),  4);
        check("stab_clr_index", 32'(clr_index), 3);
        ret_once();
        check("stab_ret_cur", 32'(cur_prio), 0);

        // ---------------- stack full ----------------
        take(2'd0, 3'd1);
        take(2'd1, 3'd2);
        take(2'd2, 3'd3);
        take(2'd3, 3'd4);
        check("full_nest", 32'(nest_level), 4);
        check("full_cur",  32'(cur_prio),   4);
        arb_valid = 1'b1; arb_index = 2'd2; arb_prio = 3'd7;
        tick();
        check("full_noreq1", 32'(irq_req), 0);
        tick();
        check("full_noreq2", 32'(irq_req), 0);
        ret_once();
        check("full_ret_nest",  32'(nest_level), 3);
        check("full_ret_cur",   32'(cur_prio),   3);
        check("full_ret_noreq", 32'(irq_req),    0);
        tick();
        check("full_req",  32'(irq_req),  1);
        check("full_prio", 32'(irq_prio), 7);
        arb_valid = 1'b0; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("full_ack_nest", 32'(nest_level), 4);
        check("full_ack_cur",  32'(cur_prio),   7);
        ret_once();
        check("unwind1", 32'(cur_prio), 3);
        ret_once();
        check("unwind2", 32'(cur_prio), 2);
        ret_once();
        check("unwind3", 32'(cur_prio), 1);
        ret_once();
        check("unwind4_cur",  32'(cur_prio),   0);
        check("unwind4_nest", 32'(nest_level), 0);
        check("full_err",     32'(err),        0);

        // ---------------- errors ----------------
        ret_once();
        check("err_ret0",      32'(err),        1);
        check("err_ret0_nest", 32'(nest_level), 0);
        check("err_ret0_cur",  32'(cur_prio),   0);
        check("err_ret0_req",  32'(irq_req),    0);
        tick(); tick();
        check("err_sticky", 32'(err), 1);
        do_reset();
        check("err_cleared", 32'(err), 0);
        tick();
        arb_valid = 1'b1; arb_index = 2'd1; arb_prio = 3'd2;
        tick();
        arb_valid = 1'b0; irq_ack = 1'b1; irq_ret = 1'b1;
        tick();
        irq_ack = 1'b0; irq_ret = 1'b0;
        check("ackret_cur",  32'(cur_prio),   2);
        check("ackret_nest", 32'(nest_level), 1);
        check("ackret_clr",  32'(clr_pend),   1);
        check("ackret_err",  32'(err),        1);

        // ---------------- reset mid-request ----------------
        arb_valid = 1'b1; arb_index = 2'd3; arb_prio = 3'd6;
        tick();
        check("midreq_req", 32'(irq_req), 1);
        rst_n = 1'b0;
        #2;
        check("midreq_drop", 32'(irq_req),    0);
        check("midreq_nest", 32'(nest_level), 0);
        check("midreq_cur",  32'(cur_prio),   0);
        check("midreq_err",  32'(err),        0);
        arb_valid = 1'b0;
        rst_n = 1'b1;
        tick();

`ifdef CAN_CLIC_THRESHOLD_EN
        // ---------------- threshold ----------------
        threshold = 3'd5;
        arb_valid = 1'b1; arb_index = 2'd0; arb_prio = 3'd4;
        tick();
        check("thr_below", 32'(irq_req), 0);
        arb_prio = 3'd6;
        tick();
        check("thr_above",      32'(irq_req),  1);
        check("thr_above_prio", 32'(irq_prio), 6);
        threshold = 3'd7;
        tick();
        check("thr_not_withdrawn", 32'(irq_req), 1);
        arb_valid = 1'b0;
        threshold = 3'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
